// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-line instruction cache with a req/ack refill FSM to a slow ROM.
// Define ICACHE_STAT_EN to add hit/miss counters (hit_cnt, miss_cnt).
module icache_dm #(
    parameter int unsigned INDEX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [31:0] pc_addr,
    input  logic        flush,
    output logic [31:0] instr_o,
    output logic        stall_req,
    output logic        rom_req,
    output logic [31:0] rom_addr,
    input  logic        rom_ack,
    input  logic [31:0] rom_data
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int unsigned TAG_W = 30 - INDEX_W;
    localparam int unsigned Lines = 2 ** INDEX_W;

    typedef enum logic {StIdle, StReq} state_e;

    state_e             state_q, state_d;
    logic [Lines-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_arr [Lines];
    logic [31:0]        data_arr [Lines];
    logic [31:0]        rom_addr_q;
    logic               flush_pending_q;

    logic [INDEX_W-1:0] idx, fill_idx;
    logic [TAG_W-1:0]   tag, fill_tag;
    logic               hit, miss_start, fill;
    logic               unused_pc_lsb;

    assign idx           = pc_addr[INDEX_W+1:2];
    assign tag           = pc_addr[31:INDEX_W+2];
    // The latched refill address doubles as the miss index/tag.
    assign fill_idx      = rom_addr_q[INDEX_W+1:2];
    assign fill_tag      = rom_addr_q[31:INDEX_W+2];
    assign unused_pc_lsb = ^pc_addr[1:0];

    assign hit        = ce & valid_q[idx] & (tag_arr[idx] == tag);
    assign miss_start = (state_q == StIdle) & ce & ~hit;
    assign fill       = (state_q == StReq) & rom_ack;

    always_comb begin
        state_d   = state_q;
        instr_o   = '0;
        stall_req = 1'b0;
        rom_req   = 1'b0;
        rom_addr  = rst ? '0 : rom_addr_q;
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    if (hit) begin
                        instr_o = data_arr[idx];
                    end else if (ce) begin
                        stall_req = 1'b1;
                        state_d   = StReq;
                    end
                end
                StReq: begin
                    rom_req   = 1'b1;
                    stall_req = 1'b1;
                    if (rom_ack) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            valid_q         <= '0;
            rom_addr_q      <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (miss_start) begin
                rom_addr_q <= {pc_addr[31:2], 2'b00};
            end
            if (state_q == StReq) begin
                flush_pending_q <= rom_ack ? 1'b0 : (flush_pending_q | flush);
            end else begin
                flush_pending_q <= 1'b0;
            end
            if (fill && !flush_pending_q) begin
                valid_q[fill_idx] <= 1'b1;
            end
            // Flush overrides a same-cycle refill so the line ends invalid.
            if (flush) begin
                valid_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill && !rst) begin
            data_arr[fill_idx] <= rom_data;
            tag_arr[fill_idx]  <= fill_tag;
        end
    end

`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if ((state_q == StIdle) && hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_start) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: cycle-by-cycle vector table plus refill/flush sequences.
module tb_icache_dm;

    logic        clk = 1'b0;
    logic        rst, ce, flush, rom_ack;
    logic [31:0] pc_addr, rom_data;
    logic [31:0] instr_o, rom_addr;
    logic        stall_req, rom_req;
`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    icache_dm dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .pc_addr   (pc_addr),
        .flush     (flush),
        .instr_o   (instr_o),
        .stall_req (stall_req),
        .rom_req   (rom_req),
        .rom_addr  (rom_addr),
        .rom_ack   (rom_ack),
        .rom_data  (rom_data)
`ifdef ICACHE_STAT_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    typedef struct {
        logic        rst;
        logic        ce;
        logic [31:0] pc;
        logic        flush;
        logic        ack;
        logic [31:0] data;
        logic [31:0] ei;
        logic        es;
        logic        er;
        logic [31:0] ea;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic c, input logic [31:0] p,
                                input logic f, input logic a, input logic [31:0] d,
                                input logic [31:0] ei, input logic es, input logic er,
                                input logic [31:0] ea);
        vec_t v;
        v.rst = r; v.ce = c; v.pc = p; v.flush = f; v.ack = a; v.data = d;
        v.ei = ei; v.es = es; v.er = er; v.ea = ea;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic drive(input logic r, input logic c, input logic [31:0] p, input logic f,
                         input logic a, input logic [31:0] d);
        @(posedge clk);
        #1;
        rst = r; ce = c; pc_addr = p; flush = f; rom_ack = a; rom_data = d;
    endtask

    task automatic refill(input logic [31:0] pc, input logic [31:0] d);
        int n = 0;
        do begin
            drive(0, 1, pc, 0, 0, 0);
            @(negedge clk);
            n++;
        end while (!rom_req && n < 8);
        chk("refill rom_req", {31'd0, rom_req}, 32'd1);
        chk("refill rom_addr", rom_addr, pc);
        drive(0, 1, pc, 0, 1, d);
        @(negedge clk);
        drive(0, 1, pc, 0, 0, 0);
        @(negedge clk);
        chk("refill hit stall", {31'd0, stall_req}, 32'd0);
        chk("refill hit instr", instr_o, d);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; pc_addr = '0; flush = 1'b0; rom_ack = 1'b0; rom_data = '0;

        //                rst ce pc            fl ack data          instr         st rq addr
        vecs.push_back(mk(1, 1, 32'h00000000, 0, 0, 32'h0,        32'h0,        0, 0, 32'h00));
        vecs.push_back(mk(0, 1, 32'h00000000, 0, 0, 32'h0,        32'h0,        1, 0, 32'h00));
        vecs.push_back(mk(0, 1, 32'h00000000, 0, 0, 32'h0,        32'h0,        1, 1, 32'h00));
        vecs.push_back(mk(0, 1, 32'h00000000, 0, 0, 32'h0,        32'h0,        1, 1, 32'h00));
        vecs.push_back(mk(0, 1, 32'h00000000, 0, 0, 32'h0,        32'h0,        1, 1, 32'h00));
        vecs.push_back(mk(0, 1, 32'h00000000, 0, 1, 32'h34010005, 32'h0,        1, 1, 32'h00));
        vecs.push_back(mk(0, 1, 32'h00000000, 0, 0, 32'h0,        32'h34010005, 0, 0, 32'h00));
        // Conflict on index 0.
        vecs.push_back(mk(0, 1, 32'h00000100, 0, 0, 32'h0,        32'h0,        1, 0, 32'h00));
        vecs.push_back(mk(0, 1, 32'h00000100, 0, 1, 32'hAAAA0100, 32'h0,        1, 1, 32'h100));
        vecs.push_back(mk(0, 1, 32'h00000100, 0, 0, 32'h0,        32'hAAAA0100, 0, 0, 32'h100));
        vecs.push_back(mk(0, 1, 32'h00000000, 0, 0, 32'h0,        32'h0,        1, 0, 32'h100));
        vecs.push_back(mk(0, 1, 32'h00000000, 0, 1, 32'h34010005, 32'h0,        1, 1, 32'h00));
        // Flush in IDLE after filling 0x4.
        vecs.push_back(mk(0, 1, 32'h00000004, 0, 0, 32'h0,        32'h0,        1, 0, 32'h00));
        vecs.push_back(mk(0, 1, 32'h00000004, 0, 1, 32'h11110004, 32'h0,        1, 1, 32'h04));
        vecs.push_back(mk(0, 1, 32'h00000004, 1, 0, 32'h0,        32'h11110004, 0, 0, 32'h04));
        vecs.push_back(mk(0, 1, 32'h00000004, 0, 0, 32'h0,        32'h0,        1, 0, 32'h04));
        vecs.push_back(mk(0, 1, 32'h00000004, 0, 1, 32'h11110004, 32'h0,        1, 1, 32'h04));
        // Flush coincident with ack for 0x8.
        vecs.push_back(mk(0, 1, 32'h00000008, 0, 0, 32'h0,        32'h0,        1, 0, 32'h04));
        vecs.push_back(mk(0, 1, 32'h00000008, 1, 1, 32'h22220008, 32'h0,        1, 1, 32'h08));
        vecs.push_back(mk(0, 1, 32'h00000008, 0, 0, 32'h0,        32'h0,        1, 0, 32'h08));
        vecs.push_back(mk(0, 1, 32'h00000008, 0, 1, 32'h22220008, 32'h0,        1, 1, 32'h08));
        vecs.push_back(mk(0, 1, 32'h00000008, 0, 0, 32'h0,        32'h22220008, 0, 0, 32'h08));
        // PC moves to 0x20 while refilling 0x10.
        vecs.push_back(mk(0, 1, 32'h00000010, 0, 0, 32'h0,        32'h0,        1, 0, 32'h08));
        vecs.push_back(mk(0, 1, 32'h00000020, 0, 0, 32'h0,        32'h0,        1, 1, 32'h10));
        vecs.push_back(mk(0, 1, 32'h00000020, 0, 0, 32'h0,        32'h0,        1, 1, 32'h10));
        vecs.push_back(mk(0, 1, 32'h00000020, 0, 1, 32'h33330010, 32'h0,        1, 1, 32'h10));
        vecs.push_back(mk(0, 1, 32'h00000020, 0, 0, 32'h0,        32'h0,        1, 0, 32'h10));
        vecs.push_back(mk(0, 1, 32'h00000020, 0, 1, 32'h44440020, 32'h0,        1, 1, 32'h20));
        vecs.push_back(mk(0, 1, 32'h00000010, 0, 0, 32'h0,        32'h33330010, 0, 0, 32'h20));
        vecs.push_back(mk(0, 1, 32'h00000020, 0, 0, 32'h0,        32'h44440020, 0, 0, 32'h20));
        // ce=0, stray ack in IDLE is ignored.
        vecs.push_back(mk(0, 0, 32'h00000030, 0, 1, 32'h0000DEAD, 32'h0,        0, 0, 32'h20));
        vecs.push_back(mk(0, 1, 32'h00000030, 0, 0, 32'h0,        32'h0,        1, 0, 32'h20));
        // Reset mid-REQ, late ack two cycles on.
        vecs.push_back(mk(1, 1, 32'h00000030, 0, 0, 32'h0,        32'h0,        0, 0, 32'h00));
        vecs.push_back(mk(0, 0, 32'h00000030, 0, 0, 32'h0,        32'h0,        0, 0, 32'h00));
        vecs.push_back(mk(0, 0, 32'h00000030, 0, 1, 32'h00005555, 32'h0,        0, 0, 32'h00));
        vecs.push_back(mk(0, 1, 32'h00000030, 0, 0, 32'h0,        32'h0,        1, 0, 32'h00));
        vecs.push_back(mk(0, 1, 32'h00000030, 0, 1, 32'h66660030, 32'h0,        1, 1, 32'h30));
        vecs.push_back(mk(0, 1, 32'h00000000, 0, 0, 32'h0,        32'h0,        1, 0, 32'h30));
        vecs.push_back(mk(0, 1, 32'h00000000, 0, 1, 32'h34010005, 32'h0,        1, 1, 32'h00));
        vecs.push_back(mk(0, 1, 32'h00000000, 0, 0, 32'h0,        32'h34010005, 0, 0, 32'h00));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].ce, vecs[i].pc, vecs[i].flush, vecs[i].ack,
                  vecs[i].data);
            @(negedge clk);
            chk($sformatf("v%0d instr_o", i), instr_o, vecs[i].ei);
            chk($sformatf("v%0d stall_req", i), {31'd0, stall_req}, {31'd0, vecs[i].es});
            chk($sformatf("v%0d rom_req", i), {31'd0, rom_req}, {31'd0, vecs[i].er});
            chk($sformatf("v%0d rom_addr", i), rom_addr, vecs[i].ea);
        end

        // Flush one cycle before the ack inside REQ: the refill must not validate the line.
        begin
            int n = 0;
            do begin
                drive(0, 1, 32'h40, 0, 0, 0);
                @(negedge clk);
                n++;
            end while (!rom_req && n < 8);
            chk("seqA rom_req", {31'd0, rom_req}, 32'd1);
            chk("seqA rom_addr", rom_addr, 32'h40);
        end
        drive(0, 1, 32'h40, 1, 0, 0);
        @(negedge clk);
        chk("seqA req held", {31'd0, rom_req}, 32'd1);
        drive(0, 1, 32'h40, 0, 1, 32'h77770040);
        @(negedge clk);
        drive(0, 1, 32'h40, 0, 0, 0);
        @(negedge clk);
        chk("seqA refetch miss", {31'd0, stall_req}, 32'd1);
        chk("seqA no req after ack", {31'd0, rom_req}, 32'd0);
        refill(32'h40, 32'h77770040);
        drive(0, 1, 32'h0, 0, 0, 0);
        @(negedge clk);
        chk("seqA line0 flushed", {31'd0, stall_req}, 32'd1);
        refill(32'h0, 32'h34010005);

`ifdef ICACHE_STAT_EN
        drive(1, 0, 32'h0, 0, 0, 0);
        @(negedge clk);
        chk("stat reset hit", hit_cnt, 32'd0);
        chk("stat reset miss", miss_cnt, 32'd0);
        refill(32'h0, 32'h34010005);
        refill(32'h4, 32'h11110004);
        refill(32'h8, 32'h22220008);
        drive(0, 1, 32'h0, 0, 0, 0);
        @(negedge clk);
        drive(0, 1, 32'h4, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 0, 0);
        @(negedge clk);
        chk("stat miss_cnt", miss_cnt, 32'd3);
        chk("stat hit_cnt", hit_cnt, 32'd5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
